// File: rtl/pathsy_pkg.sv
// Shared types and width helpers for the primary-ray path.
// Pixel widths fall back to 10/9 bits (640x480) when not set by the build.
`ifndef PX_WIDTH
`define PX_WIDTH 10
`endif
`ifndef PY_WIDTH
`define PY_WIDTH 9
`endif
`ifndef RPP
`define RPP 4
`endif

package pathsy_pkg;

  typedef enum logic [2:0] {
    PRS_IDLE  = 3'd0,
    PRS_ISSUE = 3'd1,
    PRS_GEN   = 3'd2,
    PRS_DRAIN = 3'd3,
    PRS_DONE  = 3'd4
  } prs_state_t;

  function automatic int prs_credit_w(input int max_inflight);
    return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/primary_ray_scheduler_raster_walker.sv
// Raster-order pixel position with clear/advance controls.
// last_pixel flags the bottom-right pixel of the image.
module raster_walker
  import pathsy_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 adv,
  output logic [`PX_WIDTH-1:0] x,
  output logic [`PY_WIDTH-1:0] y,
  output logic                 last_pixel
);

  localparam int XW = `PX_WIDTH;
  localparam int YW = `PY_WIDTH;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/primary_ray_scheduler.sv
// Frame sequencer issuing pixels to primary-ray generation, credit-limited.
// Optional stall counter enabled by defining PRS_STALL_CNT_EN.
module primary_ray_scheduler
  import pathsy_pkg::*;
#(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  output logic                 frame_busy,
  output logic                 frame_done,
  output logic                 gen_start,
  output logic [`PX_WIDTH-1:0] gen_x,
  output logic [`PY_WIDTH-1:0] gen_y,
  input  logic                 gen_busy,
  input  logic                 pix_retire
`ifdef PRS_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int CW = prs_credit_w(MAX_INFLIGHT);
  localparam logic [CW-1:0] CRED_MAX = CW'(MAX_INFLIGHT);

  prs_state_t    state;
  prs_state_t    state_nx;
  logic [CW-1:0] inflight;
  logic          credit_ok;
  logic          accept;
  logic          advance;
  logic          retire;
  logic          drained;
  logic          last_pixel;

  assign credit_ok = inflight < CRED_MAX;
  assign accept    = (state == PRS_IDLE) && frame_start;
  assign gen_start = (state == PRS_ISSUE) && credit_ok;
  assign advance   = (state == PRS_GEN) && !gen_busy && !last_pixel;
  assign drained   = (state == PRS_DRAIN) && (inflight == '0);
  // Retires with nothing outstanding are dropped.
  assign retire    = pix_retire && (inflight != '0);

  raster_walker #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_walk (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .adv       (advance),
    .x         (gen_x),
    .y         (gen_y),
    .last_pixel(last_pixel)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      PRS_IDLE:  if (frame_start) state_nx = PRS_ISSUE;
      PRS_ISSUE: if (credit_ok) state_nx = PRS_GEN;
      PRS_GEN:
        if (!gen_busy) state_nx = last_pixel ? PRS_DRAIN : PRS_ISSUE;
      PRS_DRAIN: if (inflight == '0) state_nx = PRS_DONE;
      PRS_DONE:  state_nx = PRS_IDLE;
      default:   state_nx = PRS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= PRS_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (gen_start && !retire) begin
      inflight <= inflight + CW'(1);
    end else if (!gen_start && retire) begin
      inflight <= inflight - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= drained;
      if (accept)       frame_busy <= 1'b1;
      else if (drained) frame_busy <= 1'b0;
    end
  end

`ifdef PRS_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cycles <= '0;
    end else if ((state == PRS_ISSUE) && (inflight == CRED_MAX)
                 && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_primary_ray_scheduler.sv
// Self-checking bench for primary_ray_scheduler on a 4x2 image.
// Stall counter checks compile in when PRS_STALL_CNT_EN is defined.
module tb_primary_ray_scheduler;
  import pathsy_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int MI = 2;
  localparam int BUSY = 5;

  typedef struct {
    int x;
    int y;
  } pix_t;

  typedef struct {
    bit mid_start;
    int exp_gen;
    int exp_done;
  } run_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic frame_busy, frame_done, gen_start;
  logic [`PX_WIDTH-1:0] gen_x;
  logic [`PY_WIDTH-1:0] gen_y;
  logic gen_busy;
  logic pix_retire;
`ifdef PRS_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  logic auto_en = 1'b0;
  logic auto_ret;
  logic man_ret = 1'b0;
  int busy_cnt;
  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int gen_cnt = 0;
  int done_cnt = 0;
  int held_x, held_y;
  int k, r_cyc;
  pix_t exp_q[$];
  pix_t pix_tbl[8];
  run_t runs[2];

  primary_ray_scheduler #(
    .IMG_W(W),
    .IMG_H(H),
    .MAX_INFLIGHT(MI)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .gen_start  (gen_start),
    .gen_x      (gen_x),
    .gen_y      (gen_y),
    .gen_busy   (gen_busy),
    .pix_retire (pix_retire)
`ifdef PRS_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generation stage model: busy for BUSY cycles after each start.
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (gen_start) busy_cnt <= BUSY;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign gen_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (rst) auto_ret <= 1'b0;
    else auto_ret <= auto_en && gen_start;
  end
  assign pix_retire = auto_ret | man_ret;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (gen_start) begin
        gen_cnt++;
        if (exp_q.size() == 0) begin
          chk("gen_unexpected", 1, 0);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          chk("gen_x", int'(gen_x), e.x);
          chk("gen_y", int'(gen_y), e.y);
        end
        held_x = int'(gen_x);
        held_y = int'(gen_y);
      end else if (gen_busy) begin
        chk("xy_stable", (int'(gen_x) << 16) | int'(gen_y),
            (held_x << 16) | held_y);
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < W * H; i++) exp_q.push_back(pix_tbl[i]);
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_gen(input int n, input int budget);
    int i;
    i = 0;
    while (gen_cnt < n && i < budget) begin
      step();
      i++;
    end
    chk("wait_gen_timeout", int'(gen_cnt >= n), 1);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_cnt < 1 && i < budget) begin
      step();
      i++;
    end
    chk("wait_done_timeout", int'(done_cnt >= 1), 1);
  endtask

  task automatic check_frame_end(input int exp_gen, input int exp_done);
    repeat (10) step();
    chk("gen_count", gen_cnt, exp_gen);
    chk("done_count", done_cnt, exp_done);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_after_done", int'(frame_busy), 0);
    chk("inflight_after_done", int'(dut.inflight), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_tbl[0] = '{0, 0};
    pix_tbl[1] = '{1, 0};
    pix_tbl[2] = '{2, 0};
    pix_tbl[3] = '{3, 0};
    pix_tbl[4] = '{0, 1};
    pix_tbl[5] = '{1, 1};
    pix_tbl[6] = '{2, 1};
    pix_tbl[7] = '{3, 1};
    runs[0] = '{1'b0, 8, 1};
    runs[1] = '{1'b1, 8, 1};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_frame_busy", int'(frame_busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_gen_start", int'(gen_start), 0);
    chk("rst_gen_x", int'(gen_x), 0);
    chk("rst_gen_y", int'(gen_y), 0);
    chk("rst_inflight", int'(dut.inflight), 0);
`ifdef PRS_STALL_CNT_EN
    chk("rst_stall", int'(stall_cycles), 0);
`endif

    // Full frames with immediate retire; second has a mid-frame start.
    for (int r = 0; r < 2; r++) begin
      gen_cnt = 0;
      done_cnt = 0;
      auto_en = 1'b1;
      push_frame();
      pulse_start();
      chk("accept_busy", int'(frame_busy), 1);
      chk("first_gen_start", int'(gen_start), 1);
      if (runs[r].mid_start) begin
        repeat (20) step();
        chk("mid_busy", int'(frame_busy), 1);
        pulse_start();
      end
      wait_done(600);
      check_frame_end(runs[r].exp_gen, runs[r].exp_done);
    end

    // Retires withheld: park in ISSUE, then release one credit.
    gen_cnt = 0;
    done_cnt = 0;
    auto_en = 1'b0;
    push_frame();
    pulse_start();
    wait_gen(2, 100);
    k = cyc;
    while (cyc < k + 30) step();
    r_cyc = cyc;
    chk("parked_no_start", int'(gen_start), 0);
    chk("parked_gen_cnt", gen_cnt, 2);
    chk("parked_state", int'(dut.state), int'(PRS_ISSUE));
    man_ret = 1'b1;
    step();
    chk("release_gen_start", int'(gen_start), 1);
    chk("release_gen_cnt", gen_cnt, 3);
`ifdef PRS_STALL_CNT_EN
    chk("stall_cycles", int'(stall_cycles), r_cyc - k - 6);
`endif
    step();
    chk("same_cycle_inflight", int'(dut.inflight), 1);
    step();
    man_ret = 1'b0;
    chk("drained_inflight", int'(dut.inflight), 0);
    auto_en = 1'b1;
    wait_done(600);
    check_frame_end(8, 1);

    // Spurious retires in IDLE must not create extra credit.
    man_ret = 1'b1;
    repeat (3) step();
    man_ret = 1'b0;
    step();
    chk("spurious_inflight", int'(dut.inflight), 0);
    gen_cnt = 0;
    auto_en = 1'b0;
    push_frame();
    pulse_start();
    repeat (60) step();
    chk("credit_limit_gen_cnt", gen_cnt, MI);
    chk("credit_limit_state", int'(dut.state), int'(PRS_ISSUE));
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();

    // Reset while pixel (2,1) is in generation.
    gen_cnt = 0;
    done_cnt = 0;
    auto_en = 1'b1;
    push_frame();
    pulse_start();
    wait_gen(7, 200);
    step();
    step();
    chk("pre_rst_gen_busy", int'(gen_busy), 1);
    chk("pre_rst_x", int'(gen_x), 2);
    chk("pre_rst_y", int'(gen_y), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_frame_busy", int'(frame_busy), 0);
    chk("mid_rst_frame_done", int'(frame_done), 0);
    chk("mid_rst_gen_start", int'(gen_start), 0);
    chk("mid_rst_gen_x", int'(gen_x), 0);
    chk("mid_rst_gen_y", int'(gen_y), 0);
    chk("mid_rst_inflight", int'(dut.inflight), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) step();
    chk("post_rst_no_start", int'(gen_start), 0);

    gen_cnt = 0;
    done_cnt = 0;
    push_frame();
    pulse_start();
    chk("restart_gen_start", int'(gen_start), 1);
    wait_done(600);
    check_frame_end(8, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
